// File: rtl/packet_add_sched.sv
// Round-robin job scheduler that shares one packet_add datapath among NREQ AXI-Stream requesters.
// Define PKT_SCHED_TIMEOUT_EN to enable the watchdog that aborts jobs stalled in RUN.
module packet_add_sched #(
    parameter int DW       = 8,
    parameter int NREQ     = 2,
    parameter int CFG_WAIT = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*2*DW-1:0] req_cfg,
    input  logic [NREQ*DW-1:0]   s_tdata,
    input  logic [NREQ-1:0]      s_tvalid,
    input  logic [NREQ-1:0]      s_tlast,
    output logic [NREQ-1:0]      s_tready,
    output logic [DW-1:0]        m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [2*DW-1:0]      config_packet,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [NREQ-1:0]      done_vec,
    output logic                 err_len,
    output logic                 timeout,
    output logic [1:0]           state_dbg
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(CFG_WAIT + 1);

    typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_next;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [IW:0]     cand;
    logic [CW-1:0]   cfg_cnt;
    logic [DW-1:0]   beat_cnt;
    logic [DW-1:0]   pkt_cnt;
    logic [DW-1:0]   cfg_k;
    logic [DW-1:0]   cfg_len;
    logic [DW-1:0]   k_eff;
    logic [DW:0]     beat_next;
    logic [DW:0]     pkt_next;
    logic            hs;

    // Handshake rule: a beat moves only in a cycle where both valid and ready are high;
    // valid never waits on ready, and the stream is open only in RUN.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        if (state == RUN) begin
            m_tdata         = s_tdata[owner*DW +: DW];
            m_tvalid        = s_tvalid[owner];
            m_tlast         = s_tlast[owner];
            s_tready[owner] = m_tready;
        end
    end

    assign hs        = m_tvalid & m_tready;
    assign cfg_k     = config_packet[2*DW-1:DW];
    assign cfg_len   = config_packet[DW-1:0];
    assign k_eff     = (cfg_k == '0) ? DW'(1) : cfg_k;
    assign beat_next = {1'b0, beat_cnt} + (DW+1)'(1);
    assign pkt_next  = {1'b0, pkt_cnt} + (DW+1)'(1);
    assign rr_next   = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

`ifdef PKT_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            grant         <= '0;
            config_packet <= '0;
            done_vec      <= '0;
            err_len       <= 1'b0;
            cfg_cnt       <= '0;
            beat_cnt      <= '0;
            pkt_cnt       <= '0;
`ifdef PKT_SCHED_TIMEOUT_EN
            timeout       <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
            done_vec <= '0;
`ifdef PKT_SCHED_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner         <= win_idx;
                        grant         <= NREQ'(1) << win_idx;
                        config_packet <= req_cfg[win_idx*2*DW +: 2*DW];
                        cfg_cnt       <= '0;
                        beat_cnt      <= '0;
                        pkt_cnt       <= '0;
`ifdef PKT_SCHED_TIMEOUT_EN
                        wd_cnt        <= '0;
`endif
                        state         <= CFG;
                    end
                end
                CFG: begin
                    if (cfg_cnt == CW'(CFG_WAIT - 1)) state <= RUN;
                    else cfg_cnt <= cfg_cnt + 1'b1;
                end
                RUN: begin
                    if (hs) begin
                        // A zero len disables the length check; the saturated count can never match.
                        if (m_tlast) begin
                            if (cfg_len != '0 && beat_next != {1'b0, cfg_len}) err_len <= 1'b1;
                            beat_cnt <= '0;
                            pkt_cnt  <= pkt_cnt + 1'b1;
                            if (pkt_next >= {1'b0, k_eff}) begin
                                done_vec <= grant;
                                state    <= DONE;
                            end
                        end else if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
`ifdef PKT_SCHED_TIMEOUT_EN
                        wd_cnt <= '0;
                    end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        grant   <= '0;
                        rr_ptr  <= rr_next;
                        wd_cnt  <= '0;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= rr_next;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_add_sched.sv
// Directed bench for packet_add_sched: reset, single job, round-robin, length error,
// ready back-pressure, mid-job reset, and the watchdog when PKT_SCHED_TIMEOUT_EN is defined.
module tb_packet_add_sched;
    localparam int DW       = 8;
    localparam int NREQ     = 2;
    localparam int CFG_WAIT = 2;
    localparam int TIMEOUT  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*2*DW-1:0] req_cfg;
    logic [NREQ*DW-1:0]   s_tdata;
    logic [NREQ-1:0]      s_tvalid;
    logic [NREQ-1:0]      s_tlast;
    logic [NREQ-1:0]      s_tready;
    logic [DW-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;
    logic [2*DW-1:0]      config_packet;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic [NREQ-1:0]      done_vec;
    logic                 err_len;
    logic                 timeout;
    logic [1:0]           state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   got_q[$];
    logic [DW-1:0]   data_seq = '0;
    int              done_pulses = 0;
    int              grant_overlap = 0;
    int              cfg_bad = 0;
    int              nonowner_ready = 0;
    int              timeout_pulses = 0;
    logic            prev_busy = 1'b0;
    logic [2*DW-1:0] prev_cfg = '0;

    always #5 clk = ~clk;

    packet_add_sched #(.DW(DW), .NREQ(NREQ), .CFG_WAIT(CFG_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cfg(req_cfg),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .config_packet(config_packet), .grant(grant), .busy(busy), .done_vec(done_vec),
        .err_len(err_len), .timeout(timeout), .state_dbg(state_dbg)
    );

    // Monitor: captures forwarded beats and protocol invariants once per cycle.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_busy = 1'b0;
            prev_cfg  = config_packet;
        end else begin
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
            if (done_vec != '0) done_pulses++;
            if (!$onehot0(grant)) grant_overlap++;
            if (prev_busy && config_packet != prev_cfg) cfg_bad++;
            if (timeout) timeout_pulses++;
            if ((s_tready & ~grant) != '0) nonowner_ready++;
            prev_busy = busy;
            prev_cfg  = config_packet;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives npkt packets of plen beats on requester idx; tlast marks beat plen.
    task automatic run_job(input int idx, input int npkt, input int plen, input bit toggle,
                           output int first_wait, output logic [NREQ-1:0] grant_seen,
                           output logic [NREQ-1:0] done_seen, output int stuck);
        int waited;
        bit acc;
        first_wait = -1;
        grant_seen = '0;
        stuck = 0;
        waited = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int b = 1; b <= plen; b++) begin
                acc = 1'b0;
                data_seq = data_seq + 1'b1;
                for (int g = 0; g < 200 && !acc; g++) begin
                    @(negedge clk);
                    waited++;
                    if (toggle) m_tready = ~m_tready;
                    else m_tready = 1'b1;
                    s_tdata[idx*DW +: DW] = data_seq;
                    s_tvalid[idx] = 1'b1;
                    s_tlast[idx] = (b == plen);
                    #1;
                    if (s_tready[idx]) begin
                        acc = 1'b1;
                        exp_q.push_back(data_seq);
                        if (first_wait < 0) begin
                            first_wait = waited;
                            grant_seen = grant;
                        end
                    end
                end
                if (!acc) stuck++;
            end
        end
        @(negedge clk);
        s_tvalid = '0;
        s_tlast = '0;
        m_tready = 1'b1;
        #1;
        done_seen = done_vec;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; req_cfg = '0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        @(negedge clk);
        #1;
        tests_run++; if (grant !== '0) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0", grant); end
        tests_run++; if (config_packet !== '0) begin tests_failed++; $display("FAIL reset_cfg: got %h expected 0", config_packet); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done_vec !== '0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done_vec); end
        tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_len); end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        tests_run++; if (s_tready !== '0) begin tests_failed++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
        tests_run++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_m_ctrl: got %b%b expected 00", m_tvalid, m_tlast); end
        tests_run++; if (m_tdata !== '0) begin tests_failed++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
        tests_run++; if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int fw, stuck, bad;
        logic [NREQ-1:0] gs, ds;
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        req_cfg[0 +: 2*DW] = {8'd2, 8'd64};
        req = 2'b01;
        run_job(0, 2, 64, 1'b0, fw, gs, ds, stuck);
        req = '0;
        tests_run++; if (fw != 1 + CFG_WAIT) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", fw, 1 + CFG_WAIT); end
        tests_run++; if (gs !== 2'b01) begin tests_failed++; $display("FAIL single_grant: got %b expected 01", gs); end
        tests_run++; if (stuck != 0) begin tests_failed++; $display("FAIL single_stuck: got %0d expected 0", stuck); end
        tests_run++; if (ds !== 2'b01) begin tests_failed++; $display("FAIL single_done: got %b expected 01", ds); end
        tests_run++; if (config_packet !== {8'd2, 8'd64}) begin tests_failed++; $display("FAIL single_cfg: got %h expected 0240", config_packet); end
        bad = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        tests_run++; if (got_q.size() != 128 || bad != 0) begin tests_failed++; $display("FAIL single_data: got %0d beats %0d bad expected 128 beats 0 bad", got_q.size(), bad); end
        tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", err_len); end
        @(negedge clk);
        #1;
        tests_run++; if (busy !== 1'b0 || grant !== '0 || done_vec !== '0) begin tests_failed++; $display("FAIL single_idle: got busy %b grant %b done %b expected 0 0 0", busy, grant, done_vec); end
        tests_run++; if (config_packet !== {8'd2, 8'd64}) begin tests_failed++; $display("FAIL single_cfg_hold: got %h expected 0240", config_packet); end
    endtask

    task automatic test_round_robin();
        int fw, stuck;
        logic [NREQ-1:0] gs, ds;
        do_reset();
        grant_overlap = 0;
        cfg_bad = 0;
        req_cfg = {8'd1, 8'd4, 8'd1, 8'd4};
        req = 2'b11;
        run_job(0, 1, 4, 1'b0, fw, gs, ds, stuck);
        tests_run++; if (gs !== 2'b01 || ds !== 2'b01 || stuck != 0) begin tests_failed++; $display("FAIL rr_first: got grant %b done %b stuck %0d expected 01 01 0", gs, ds, stuck); end
        run_job(1, 1, 4, 1'b0, fw, gs, ds, stuck);
        tests_run++; if (gs !== 2'b10 || ds !== 2'b10 || stuck != 0) begin tests_failed++; $display("FAIL rr_second: got grant %b done %b stuck %0d expected 10 10 0", gs, ds, stuck); end
        run_job(0, 1, 4, 1'b0, fw, gs, ds, stuck);
        req = '0;
        tests_run++; if (gs !== 2'b01 || ds !== 2'b01 || stuck != 0) begin tests_failed++; $display("FAIL rr_third: got grant %b done %b stuck %0d expected 01 01 0", gs, ds, stuck); end
        tests_run++; if (grant_overlap != 0) begin tests_failed++; $display("FAIL rr_overlap: got %0d expected 0", grant_overlap); end
        tests_run++; if (cfg_bad != 0) begin tests_failed++; $display("FAIL rr_cfg_stable: got %0d expected 0", cfg_bad); end
        tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL rr_err: got %b expected 0", err_len); end
    endtask

    task automatic test_err_len();
        int fw, stuck;
        logic [NREQ-1:0] gs, ds;
        req_cfg[2*DW +: 2*DW] = {8'd1, 8'd8};
        req = 2'b10;
        run_job(1, 1, 6, 1'b0, fw, gs, ds, stuck);
        req = '0;
        tests_run++; if (ds !== 2'b10 || stuck != 0) begin tests_failed++; $display("FAIL err_job_done: got done %b stuck %0d expected 10 0", ds, stuck); end
        tests_run++; if (err_len !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b expected 1", err_len); end
        req_cfg[0 +: 2*DW] = {8'd1, 8'd4};
        req = 2'b01;
        run_job(0, 1, 4, 1'b0, fw, gs, ds, stuck);
        req = '0;
        tests_run++; if (ds !== 2'b01) begin tests_failed++; $display("FAIL err_next_done: got %b expected 01", ds); end
        tests_run++; if (err_len !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err_len); end
    endtask

    task automatic test_tready_toggle();
        int fw, stuck, bad;
        logic [NREQ-1:0] gs, ds;
        exp_q.delete(); got_q.delete();
        nonowner_ready = 0;
        req_cfg[0 +: 2*DW] = {8'd3, 8'd5};
        req = 2'b01;
        run_job(0, 3, 5, 1'b1, fw, gs, ds, stuck);
        req = '0;
        @(negedge clk);
        bad = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        tests_run++; if (got_q.size() != 15) begin tests_failed++; $display("FAIL toggle_count: got %0d expected 15", got_q.size()); end
        tests_run++; if (exp_q.size() != 15 || bad != 0) begin tests_failed++; $display("FAIL toggle_data: got %0d sent %0d bad expected 15 sent 0 bad", exp_q.size(), bad); end
        tests_run++; if (ds !== 2'b01) begin tests_failed++; $display("FAIL toggle_done: got %b expected 01", ds); end
        tests_run++; if (nonowner_ready != 0) begin tests_failed++; $display("FAIL toggle_nonowner: got %0d expected 0", nonowner_ready); end
        tests_run++; if (err_len !== 1'b1) begin tests_failed++; $display("FAIL toggle_err_sticky: got %b expected 1", err_len); end
    endtask

    task automatic test_reset_midrun();
        int acc, dp;
        req_cfg[0 +: 2*DW] = {8'd1, 8'd20};
        req = 2'b01;
        m_tready = 1'b1;
        acc = 0;
        for (int g = 0; g < 100 && acc < 10; g++) begin
            @(negedge clk);
            data_seq = data_seq + 1'b1;
            s_tdata[0 +: DW] = data_seq;
            s_tvalid[0] = 1'b1;
            #1;
            if (s_tready[0]) acc++;
        end
        tests_run++; if (acc != 10) begin tests_failed++; $display("FAIL midrun_beats: got %0d expected 10", acc); end
        dp = done_pulses;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++; if (m_tvalid !== 1'b0 || s_tready !== '0) begin tests_failed++; $display("FAIL midrun_stream: got m_tvalid %b s_tready %b expected 0 00", m_tvalid, s_tready); end
        tests_run++; if (grant !== '0 || busy !== 1'b0 || config_packet !== '0) begin tests_failed++; $display("FAIL midrun_ctrl: got grant %b busy %b cfg %h expected 0 0 0", grant, busy, config_packet); end
        tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL midrun_err_clear: got %b expected 0", err_len); end
        @(negedge clk);
        s_tvalid = '0;
        req = 2'b11;
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL midrun_next_grant: got %b expected 01", grant); end
        tests_run++; if (done_pulses != dp) begin tests_failed++; $display("FAIL midrun_no_done: got %0d expected %0d", done_pulses, dp); end
        req = '0;
    endtask

`ifdef PKT_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int seen, dp;
        do_reset();
        req_cfg = {8'd1, 8'd4, 8'd1, 8'd4};
        dp = done_pulses;
        req = 2'b11;
        seen = -1;
        for (int n = 1; n <= 60 && seen < 0; n++) begin
            @(negedge clk);
            #1;
            if (timeout) seen = n;
        end
        tests_run++; if (seen != 3 + TIMEOUT) begin tests_failed++; $display("FAIL timeout_cycle: got %0d expected %0d", seen, 3 + TIMEOUT); end
        @(negedge clk);
        #1;
        tests_run++; if (grant !== 2'b10 || timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_next: got grant %b timeout %b expected 10 0", grant, timeout); end
        tests_run++; if (done_pulses != dp) begin tests_failed++; $display("FAIL timeout_no_done: got %0d expected %0d", done_pulses, dp); end
        req = '0;
    endtask
`else
    task automatic test_timeout();
        tests_run++; if (timeout_pulses != 0) begin tests_failed++; $display("FAIL timeout_tied: got %0d expected 0", timeout_pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_err_len();
        test_tready_toggle();
        test_reset_midrun();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/packet_add_sched.md
Name: packet_add_sched

Overview:
- Job scheduler and arbiter that shares one packet_add datapath between NREQ AXI-Stream requesters.
- Each requester raises a job request carrying its own config word {k,len}.
- The scheduler grants one requester round-robin, presents its config on config_packet, and waits CFG_WAIT cycles for the datapath to settle.
- It then routes that requester's stream into the datapath until k packets (k s_tlast beats) have passed, then releases and re-arbitrates.

Parameters:
- DW, 8, data width and width of each config field (k, len).
- NREQ, 2, number of requesters (2..8).
- CFG_WAIT, 2, cycles config_packet is held before the stream opens (min 1).
- TIMEOUT, 1024, idle-cycle limit for the optional watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  job request per requester; level, held until done_vec bit
- req_cfg  in  NREQ*2*DW  per-requester {k,len}; requester i at bits [i*2*DW +: 2*DW]
- s_tdata  in  NREQ*DW  per-requester data
- s_tvalid  in  NREQ  per-requester valid
- s_tlast  in  NREQ  per-requester last
- s_tready  out  NREQ  per-requester ready
- m_tdata  out  DW  to datapath
- m_tvalid  out  1  to datapath
- m_tlast  out  1  to datapath
- m_tready  in  1  from datapath
- config_packet  out  2*DW  {k,len} to datapath
- grant  out  NREQ  one-hot current owner
- busy  out  1  high outside IDLE
- done_vec  out  NREQ  one-cycle pulse on owner's bit at job end
- err_len  out  1  sticky; set on packet length mismatch
- timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, immediate): state=IDLE; rr_ptr=0; grant=0; config_packet=0; busy=0; done_vec=0; err_len=0; timeout=0; all s_tready=0; m_tvalid=0; m_tlast=0; m_tdata=0.
- FSM states: IDLE, CFG, RUN, DONE.
- IDLE:
  - If any req bit is set, choose the first set bit searching from rr_ptr upward, wrapping.
  - Register grant, latch req_cfg of the winner into config_packet, clear counters, go to CFG.
  - Arbitration costs 1 cycle.
- CFG:
  - Hold for exactly CFG_WAIT cycles, then go to RUN.
  - Stream is closed: all s_tready=0, m_tvalid=0.
- RUN:
  - Combinational pass-through, zero latency: m_tdata/m_tvalid/m_tlast = owner's s_tdata/s_tvalid/s_tlast; s_tready[owner] = m_tready.
  - Non-owners: s_tready=0.
  - A handshake is m_tvalid & m_tready.
  - beat_cnt increments per handshake.
  - On a handshake with tlast: compare beat_cnt+1 with len (if len≠0); mismatch sets err_len. Then reset beat_cnt and increment pkt_cnt.
  - When pkt_cnt reaches k, go to DONE in the same cycle as the last handshake.
  - k=0 is treated as k=1.
- DONE:
  - 1 cycle: done_vec[owner]=1, stream closed.
  - rr_ptr = owner+1 mod NREQ, grant=0, go to IDLE.
  - The owner's req is ignored in the DONE cycle. If it is still high in IDLE, it competes normally behind the other requesters.
- config_packet is stable from CFG entry through DONE and keeps its value in IDLE until the next grant.
- Dropping req mid-job has no effect; the job runs to k packets.
- len=0 disables the length check; beat_cnt saturates at 2^DW-1.
- Simultaneous requests are resolved purely by rr_ptr. No requester waits more than NREQ-1 jobs.
- Reset mid-RUN aborts the job without a done_vec pulse; the datapath sees m_tvalid drop immediately.

Optional Feature:
- Macro: PKT_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts RUN cycles without a handshake and clears on each handshake.
  - When the count reaches TIMEOUT: pulse timeout for 1 cycle, close the stream, skip done_vec, advance rr_ptr, go to IDLE.
- Undefined: no counter logic; timeout is tied to 0 and RUN waits indefinitely.

Test Plan:
- Req0 only, cfg {k=2,len=64}, 128 beats with tlast at beats 64/128, m_tready=1 → grant=01 for whole job; first m_tvalid 1+CFG_WAIT cycles after req; data identical and zero latency; done_vec=01 one cycle after beat 128; err_len=0.
- Req0 and req1 both high at reset release, each {k=1,len=4} → req0 served first, then req1, then req0 again if still high; grant never overlaps; config_packet switches only in IDLE→CFG.
- Req1 {k=1,len=8} sends tlast on beat 6 → err_len=1 and stays 1 through later jobs until reset; job still completes.
- m_tready toggled every other cycle during a {k=3,len=5} job → exactly 15 handshakes forwarded, no beat lost or duplicated, s_tready of non-owner stays 0.
- Assert rst mid-RUN at beat 10 → outputs zero within the same cycle (asynchronous reset), no done_vec, next grant goes to req0.
- With PKT_SCHED_TIMEOUT_EN and TIMEOUT=16, owner stalls s_tvalid=0 in RUN → timeout pulse at stall cycle 16, return to IDLE, other requester granted next.
